// File: rtl/or_gate_sequencer_if.sv
// +----------------------------------------------------------------------------+
// | or_gate_sequencer_if : stimulus/response bundle between sequencer and gate |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface or_gate_sequencer_if #(
   parameter int CNT_W = 8
);
   logic             start;
   logic             out1_fb;
   logic             in1;
   logic             in2;
   logic [1:0]       vec_idx;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_count;

   modport master (
      input  start,
      input  out1_fb,
      output in1,
      output in2,
      output vec_idx,
      output busy,
      output done,
      output pass,
      output err_count
   );

   modport slave (
      output start,
      output out1_fb,
      input  in1,
      input  in2,
      input  vec_idx,
      input  busy,
      input  done,
      input  pass,
      input  err_count
   );
endinterface

`default_nettype wire

// File: rtl/or_gate_sequencer.sv
// +----------------------------------------------------------------------------+
// | or_gate_sequencer : walks a 2-input OR gate through all four vectors,     |
// | checks its feedback and reports a saturating mismatch count / pass flag.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module or_gate_sequencer #(
   parameter int HOLD_CYCLES = 1,
   parameter int CNT_W       = 8
) (
   input  wire                  clk,
   input  wire                  rst_n,
   or_gate_sequencer_if.master  bus
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  c_ERR_MAX   = '1;
   localparam logic [1:0]        c_VEC_LAST  = 2'd3;

   if (HOLD_CYCLES < 1) begin : g_hold_chk
      $error("or_gate_sequencer: HOLD_CYCLES must be at least 1");
   end

   if (CNT_W < 1) begin : g_cnt_chk
      $error("or_gate_sequencer: CNT_W must be at least 1");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRIVE = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [HOLD_W-1:0]  r_hold_cnt;
   logic [HOLD_W-1:0]  w_hold_nxt;
   logic [1:0]         r_vec_idx;
   logic [1:0]         w_vec_nxt;
   logic [CNT_W-1:0]   r_err_count;
   logic [CNT_W-1:0]   w_err_nxt;

   logic               r_in1;
   logic               r_in2;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;

   logic               w_in1_nxt;
   logic               w_in2_nxt;
   logic               w_busy_nxt;
   logic               w_done_nxt;
   logic               w_pass_nxt;
   logic               w_mismatch;
   logic               w_err_sat;

   // Compare against the registered vector, so the check needs no extra decode
   assign w_mismatch = bus.out1_fb != (r_in1 | r_in2);
   assign w_err_sat  = (r_err_count == c_ERR_MAX);

   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold_cnt;
      w_vec_nxt   = r_vec_idx;
      w_err_nxt   = r_err_count;

      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               w_state_nxt = S_DRIVE;
               w_hold_nxt  = '0;
               w_vec_nxt   = '0;
               w_err_nxt   = '0;
            end
         end

         S_DRIVE: begin
            w_hold_nxt = r_hold_cnt + HOLD_W'(1);
            if (r_hold_cnt == c_HOLD_LAST) begin
               w_state_nxt = S_CHECK;
            end
         end

         S_CHECK: begin
            if (w_mismatch && !w_err_sat) begin
               w_err_nxt = r_err_count + CNT_W'(1);
            end
            w_hold_nxt = '0;
            if (r_vec_idx == c_VEC_LAST) begin
               w_state_nxt = S_DONE;
               w_vec_nxt   = '0;
            end else begin
               w_state_nxt = S_DRIVE;
               w_vec_nxt   = r_vec_idx + 2'd1;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are precomputed from next-state so they appear at the same edge as the state
   always_comb begin
      w_busy_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_CHECK);
      w_done_nxt = (w_state_nxt == S_DONE);
      w_pass_nxt = w_done_nxt && (w_err_nxt == '0);
      w_in1_nxt  = w_busy_nxt && w_vec_nxt[0];
      w_in2_nxt  = w_busy_nxt && w_vec_nxt[1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_hold_cnt  <= '0;
         r_vec_idx   <= '0;
         r_err_count <= '0;
         r_in1       <= 1'b0;
         r_in2       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_hold_cnt  <= w_hold_nxt;
         r_vec_idx   <= w_vec_nxt;
         r_err_count <= w_err_nxt;
         r_in1       <= w_in1_nxt;
         r_in2       <= w_in2_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_pass      <= w_pass_nxt;
      end
   end

   assign bus.in1       = r_in1;
   assign bus.in2       = r_in2;
   assign bus.vec_idx   = r_vec_idx;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.err_count = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_or_gate_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_or_gate_sequencer : scoreboard bench over three sequencer configurations|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_or_gate_sequencer;

   localparam int M_IDEAL = 0;
   localparam int M_S0    = 1;
   localparam int M_S1    = 2;
   localparam int M_AND   = 3;

   typedef struct {
      logic       in1;
      logic       in2;
      logic       busy;
      logic       done;
      logic       pass;
      logic [7:0] err;
      logic [1:0] vec;
      bit         chk_vec;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic inj   = 1'b0;
   int   sel   = 0;
   int   mode  = M_IDEAL;

   int   n_checks = 0;
   int   n_err    = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic gate_out(input int md, input logic a, input logic b);
      case (md)
         M_S0:    return 1'b0;
         M_S1:    return 1'b1;
         M_AND:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // Three configurations: default, long hold, 1-bit counter
   or_gate_sequencer_if #(.CNT_W(8)) if_a ();
   or_gate_sequencer_if #(.CNT_W(8)) if_b ();
   or_gate_sequencer_if #(.CNT_W(1)) if_c ();

   assign if_a.start   = start && (sel == 0);
   assign if_b.start   = start && (sel == 1);
   assign if_c.start   = start && (sel == 2);
   assign if_a.out1_fb = gate_out(mode, if_a.in1, if_a.in2) ^ inj;
   assign if_b.out1_fb = gate_out(mode, if_b.in1, if_b.in2) ^ inj;
   assign if_c.out1_fb = gate_out(mode, if_c.in1, if_c.in2) ^ inj;

   or_gate_sequencer #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   or_gate_sequencer #(.HOLD_CYCLES(3), .CNT_W(8)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   or_gate_sequencer #(.HOLD_CYCLES(1), .CNT_W(1)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   logic        obs_in1, obs_in2, obs_busy, obs_done, obs_pass;
   logic [7:0]  obs_err;
   logic [1:0]  obs_vec;
   logic [12:0] obs_word;

   always_comb begin
      obs_in1  = if_a.in1;
      obs_in2  = if_a.in2;
      obs_busy = if_a.busy;
      obs_done = if_a.done;
      obs_pass = if_a.pass;
      obs_err  = if_a.err_count;
      obs_vec  = if_a.vec_idx;
      case (sel)
         1: begin
            obs_in1  = if_b.in1;
            obs_in2  = if_b.in2;
            obs_busy = if_b.busy;
            obs_done = if_b.done;
            obs_pass = if_b.pass;
            obs_err  = if_b.err_count;
            obs_vec  = if_b.vec_idx;
         end
         2: begin
            obs_in1  = if_c.in1;
            obs_in2  = if_c.in2;
            obs_busy = if_c.busy;
            obs_done = if_c.done;
            obs_pass = if_c.pass;
            obs_err  = 8'(if_c.err_count);
            obs_vec  = if_c.vec_idx;
         end
         default: ;
      endcase
   end

   assign obs_word = {obs_in1, obs_in2, obs_busy, obs_done, obs_pass, obs_err};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
      end
   endtask

   function automatic exp_t mk(input logic i1, input logic i2, input logic bsy, input logic dn,
                               input logic ps, input int err, input int vec, input bit cv);
      exp_t e;
      e.in1     = i1;
      e.in2     = i2;
      e.busy    = bsy;
      e.done    = dn;
      e.pass    = ps;
      e.err     = 8'(err);
      e.vec     = 2'(vec);
      e.chk_vec = cv;
      return e;
   endfunction

   function automatic logic [12:0] exp_word(input exp_t e);
      return {e.in1, e.in2, e.busy, e.done, e.pass, e.err};
   endfunction

   // One run: expected cycle-by-cycle outputs are queued, then popped at each negedge.
   // rst3: reset at E0+3; pulse4: stray start at E0+4; keep: start held for a relaunch.
   task automatic run(input string name, input int dut, input int hold, input int cw,
                      input int md, input bit use_inj, input bit rst3, input bit pulse4,
                      input bit keep);
      int   n;
      int   err;
      int   maxe;
      int   c;
      int   len;
      logic a;
      logic b;
      exp_t e;

      sel  = dut;
      mode = md;
      inj  = 1'b0;
      n    = 4 * (hold + 1);
      maxe = (1 << cw) - 1;
      err  = 0;
      c    = 0;
      sb.delete();

      for (int k = 0; k < 4; k++) begin
         a = k[0];
         b = k[1];
         for (int h = 0; h <= hold; h++) begin
            if (!rst3 || c < 3) sb.push_back(mk(a, b, 1'b1, 1'b0, 1'b0, err, k, 1'b1));
            c++;
         end
         if ((gate_out(md, a, b) != (a | b)) && (err < maxe)) err++;
      end
      if (rst3) begin
         sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1));
      end else begin
         sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, (err == 0), err, 0, 1'b0));
         if (keep) sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1));
      end
      len = sb.size();

      @(negedge clk);
      start = 1'b1;
      for (int cy = 0; cy < len; cy++) begin
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("%s.c%0d", name, cy), 32'(obs_word), 32'(exp_word(e)));
         if (e.chk_vec) chk($sformatf("%s.c%0d.vec", name, cy), 32'(obs_vec), 32'(e.vec));
         start = keep ? (cy <= n) : (pulse4 && (cy == 3));
         rst_n = !((rst3 && (cy == 2)) || (keep && (cy == n + 1)));
         inj   = use_inj && (cy >= 4) && (cy <= 6);
      end
      start = 1'b0;
      inj   = 1'b0;
      if (keep) begin
         @(negedge clk);
         chk({name, ".rst_busy"}, 32'(obs_busy), 32'd0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_a", 32'({if_a.busy, if_a.done, if_a.pass, if_a.in1, if_a.in2, if_a.vec_idx, if_a.err_count}), 32'd0);
      chk("reset_b", 32'({if_b.busy, if_b.done, if_b.pass, if_b.in1, if_b.in2, if_b.vec_idx, if_b.err_count}), 32'd0);
      chk("reset_c", 32'({if_c.busy, if_c.done, if_c.pass, if_c.in1, if_c.in2, if_c.vec_idx, if_c.err_count}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      //   name       dut hold cw mode     inj rst3 pls4 keep
      run("a_ideal",   0,  1,  8, M_IDEAL, 0,  0,   0,   0);
      run("a_stuck0",  0,  1,  8, M_S0,    0,  0,   0,   0);
      run("a_stuck1",  0,  1,  8, M_S1,    0,  0,   0,   0);
      run("a_and",     0,  1,  8, M_AND,   0,  0,   0,   0);
      run("b_ideal",   1,  3,  8, M_IDEAL, 0,  0,   0,   0);
      run("b_inject",  1,  3,  8, M_IDEAL, 1,  0,   0,   0);
      run("a_reset",   0,  1,  8, M_IDEAL, 0,  1,   0,   0);
      run("a_clean",   0,  1,  8, M_IDEAL, 0,  0,   0,   0);
      run("a_busystart",0, 1,  8, M_IDEAL, 0,  0,   1,   0);
      run("c_sat",     2,  1,  1, M_S0,    0,  0,   0,   0);
      run("a_b2b",     0,  1,  8, M_IDEAL, 0,  0,   0,   1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
